roce_stack_translation_arbiter: RTL and testbench

- Shares one virtual-to-physical address translation port between two RoCE request handlers, e.g. the READ=1 and READ=0 instances.
- Round-robin arbitrates translation requests into a registered request slice toward the translation unit.
- Records the requester ID of every accepted request in an in-order ID FIFO.
- Routes each in-order translation response back to the requester that issued it.

---
 rtl/roce_stack_translation_arbiter.sv | 131 +++++++++++++
 tb/tb_roce_stack_translation_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roce_stack_translation_arbiter.sv
// Round-robin sharing of one address translation port between two
// RoCE request handlers, with in-order response steering by ID FIFO.
module roce_stack_translation_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_W = 116,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              s0_req_valid_i,
  output logic              s0_req_ready_o,
  input  logic [63:0]       s0_req_vaddr_i,
  output logic              s0_resp_valid_o,
  input  logic              s0_resp_ready_i,
  output logic [RESP_W-1:0] s0_resp_data_o,
  input  logic              s1_req_valid_i,
  output logic              s1_req_ready_o,
  input  logic [63:0]       s1_req_vaddr_i,
  output logic              s1_resp_valid_o,
  input  logic              s1_resp_ready_i,
  output logic [RESP_W-1:0] s1_resp_data_o,
  output logic              m_req_valid_o,
  input  logic              m_req_ready_i,
  output logic [63:0]       m_req_vaddr_o,
  input  logic              m_resp_valid_i,
  output logic              m_resp_ready_o,
  input  logic [RESP_W-1:0] m_resp_data_i,
  output logic [CNT_W-1:0]  outstanding_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT =
    CNT_W'(MAX_OUTSTANDING);

  logic             req_v_q;
  logic [63:0]      req_a_q;
  logic             last_q;
  logic             id_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic slot_free;
  logic can_acc;
  logic any_v;
  logic win;
  logic acc;
  logic pop;
  logic head;
  logic nonempty;

  assign slot_free = !req_v_q || m_req_ready_i;
  assign can_acc   = slot_free && (cnt_q < MAX_CNT);
  assign any_v     = s0_req_valid_i || s1_req_valid_i;
  assign acc       = can_acc && any_v;

  // Pick the winner: alternate on contention, else the lone requester.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      s0_req_valid_i && s1_req_valid_i:  win = !last_q;
      !s0_req_valid_i && s1_req_valid_i: win = 1'b1;
      default:                           win = 1'b0;
    endcase
  end

  assign s0_req_ready_o = acc && !win;
  assign s1_req_ready_o = acc && win;

  assign m_req_valid_o = req_v_q;
  assign m_req_vaddr_o = req_a_q;

  assign nonempty = (cnt_q != '0);
  assign head     = id_q[rd_q];

  assign s0_resp_valid_o = m_resp_valid_i && nonempty && !head;
  assign s1_resp_valid_o = m_resp_valid_i && nonempty && head;
  assign s0_resp_data_o  = m_resp_data_i;
  assign s1_resp_data_o  = m_resp_data_i;

  assign m_resp_ready_o = nonempty &&
    (head ? s1_resp_ready_i : s0_resp_ready_i);

  assign pop = m_resp_valid_i && m_resp_ready_o;

  assign outstanding_o = cnt_q;

  // Request slice toward the translation unit plus round-robin pointer.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      req_v_q <= 1'b0;
      req_a_q <= '0;
      last_q  <= 1'b1;
    end else if (acc) begin
      req_v_q <= 1'b1;
      req_a_q <= win ? s1_req_vaddr_i : s0_req_vaddr_i;
      last_q  <= win;
    end else if (m_req_ready_i) begin
      req_v_q <= 1'b0;
    end
  end

  // ID FIFO storage: requester of each accepted request, oldest at rd_q.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i] <= 1'b0;
      end
    end else if (acc) begin
      id_q[wr_q] <= win;
    end
  end

  // ID FIFO pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (acc) wr_q <= wr_q + PTR_W'(1);
      if (pop) rd_q <= rd_q + PTR_W'(1);
      unique case ({acc, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_roce_stack_translation_arbiter.sv
// Scoreboard bench for roce_stack_translation_arbiter: directed
// stimulus pushes expectations, negedge monitors pop and compare.
module tb_roce_stack_translation_arbiter;

  localparam int RW = 116;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s0_rv = 1'b0;
  logic          s0_rr;
  logic [63:0]   s0_va = '0;
  logic          s0_pv;
  logic          s0_pr = 1'b0;
  logic [RW-1:0] s0_pd;
  logic          s1_rv = 1'b0;
  logic          s1_rr;
  logic [63:0]   s1_va = '0;
  logic          s1_pv;
  logic          s1_pr = 1'b0;
  logic [RW-1:0] s1_pd;
  logic          m_rv;
  logic          m_rr = 1'b0;
  logic [63:0]   m_va;
  logic          m_pv = 1'b0;
  logic          m_pr;
  logic [RW-1:0] m_pd = '0;
  logic [2:0]    outst;

  typedef struct {
    logic          id;
    logic [RW-1:0] data;
  } resp_t;

  logic [63:0] exp_req [$];
  resp_t       exp_resp [$];

  int checks = 0;
  int errors = 0;

  roce_stack_translation_arbiter dut (
    .clk_i           (clk),
    .aresetn_i       (aresetn),
    .s0_req_valid_i  (s0_rv),
    .s0_req_ready_o  (s0_rr),
    .s0_req_vaddr_i  (s0_va),
    .s0_resp_valid_o (s0_pv),
    .s0_resp_ready_i (s0_pr),
    .s0_resp_data_o  (s0_pd),
    .s1_req_valid_i  (s1_rv),
    .s1_req_ready_o  (s1_rr),
    .s1_req_vaddr_i  (s1_va),
    .s1_resp_valid_o (s1_pv),
    .s1_resp_ready_i (s1_pr),
    .s1_resp_data_o  (s1_pd),
    .m_req_valid_o   (m_rv),
    .m_req_ready_i   (m_rr),
    .m_req_vaddr_o   (m_va),
    .m_resp_valid_i  (m_pv),
    .m_resp_ready_o  (m_pr),
    .m_resp_data_i   (m_pd),
    .outstanding_o   (outst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] mk(input logic [7:0] b);
    logic [119:0] w;
    w = {15{b}};
    return w[RW-1:0];
  endfunction

  function automatic resp_t er(input logic id, input logic [7:0] b);
    resp_t r;
    r.id = id;
    r.data = mk(b);
    return r;
  endfunction

  // Request monitor: every slice handshake must match the next expected vaddr.
  always @(negedge clk) begin
    if (aresetn && m_rv && m_rr) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 128'(m_va), 128'hDEAD);
      end else begin
        chk("req_vaddr", 128'(m_va), 128'(exp_req.pop_front()));
      end
    end
  end

  // Response monitor: every response handshake must route to the expected requester.
  always @(negedge clk) begin
    resp_t e;
    if (aresetn && m_pv && m_pr) begin
      if (exp_resp.size() == 0) begin
        chk("resp_unexpected", 128'({s1_pv, s0_pv}), 128'h0);
      end else begin
        e = exp_resp.pop_front();
        chk("resp_s0_valid", 128'(s0_pv), 128'(!e.id));
        chk("resp_s1_valid", 128'(s1_pv), 128'(e.id));
        chk("resp_data", 128'(e.id ? s1_pd : s0_pd), 128'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    aresetn = 1'b0;
    exp_req.delete();
    exp_resp.delete();
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_m_valid", 128'(m_rv), 128'h0);
    chk("rst_m_vaddr", 128'(m_va), 128'h0);
    chk("rst_outst", 128'(outst), 128'h0);
    chk("rst_rdy", 128'({s0_rr, s1_rr, m_pr}), 128'h0);
    chk("rst_pvalid", 128'({s0_pv, s1_pv}), 128'h0);
    aresetn = 1'b1;

    // single s0 request and its response
    m_rr = 1'b1;
    s0_rv = 1'b1;
    s0_va = 64'h1000;
    exp_req.push_back(64'h1000);
    #1;
    chk("t1_s0_ready", 128'(s0_rr), 128'h1);
    tick();
    s0_rv = 1'b0;
    chk("t1_m_valid", 128'(m_rv), 128'h1);
    chk("t1_m_vaddr", 128'(m_va), 128'h1000);
    chk("t1_outst", 128'(outst), 128'h1);
    tick();
    chk("t1_m_idle", 128'(m_rv), 128'h0);
    exp_resp.push_back(er(1'b0, 8'hAA));
    m_pv = 1'b1;
    m_pd = mk(8'hAA);
    s0_pr = 1'b1;
    tick();
    m_pv = 1'b0;
    chk("t1_outst_end", 128'(outst), 128'h0);

    // alternating grants from reset, fill to MAX_OUTSTANDING
    do_reset();
    s0_pr = 1'b0;
    s0_rv = 1'b1;
    s1_rv = 1'b1;
    s0_va = 64'h1000;
    s1_va = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      exp_req.push_back(i[0] ? 64'h2000 : 64'h1000);
      exp_resp.push_back(er(i[0], 8'h10 + 8'(i)));
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_s0_grant", 128'(s0_rr), 128'(!i[0]));
      chk("t2_s1_grant", 128'(s1_rr), 128'(i[0]));
      tick();
    end
    s1_rv = 1'b0;
    s0_va = 64'h3000;
    #1;
    chk("full_outst", 128'(outst), 128'h4);
    chk("full_s0_ready", 128'(s0_rr), 128'h0);
    tick();
    exp_req.push_back(64'h3000);
    exp_resp.push_back(er(1'b0, 8'h20));
    s0_pr = 1'b1;
    s1_pr = 1'b1;
    m_pv = 1'b1;
    m_pd = mk(8'h10);
    #1;
    chk("nobypass_ready", 128'(s0_rr), 128'h0);
    tick();
    m_pv = 1'b0;
    chk("after_pop_outst", 128'(outst), 128'h3);
    chk("after_pop_ready", 128'(s0_rr), 128'h1);
    tick();
    s0_rv = 1'b0;
    chk("refill_outst", 128'(outst), 128'h4);

    // head is s1 and s1 stalls: nothing moves for either requester
    s1_pr = 1'b0;
    m_pv = 1'b1;
    m_pd = mk(8'h11);
    #1;
    chk("bp_m_ready", 128'(m_pr), 128'h0);
    chk("bp_s0_valid", 128'(s0_pv), 128'h0);
    chk("bp_s1_valid", 128'(s1_pv), 128'h1);
    tick();
    tick();
    chk("bp_outst", 128'(outst), 128'h4);
    s1_pr = 1'b1;
    tick();
    m_pd = mk(8'h12);
    tick();
    m_pd = mk(8'h13);
    tick();
    m_pd = mk(8'h20);
    tick();
    m_pv = 1'b0;
    chk("drain_outst", 128'(outst), 128'h0);

    // response with nothing outstanding is held off
    m_pv = 1'b1;
    m_pd = mk(8'h55);
    #1;
    chk("empty_m_ready", 128'(m_pr), 128'h0);
    chk("empty_pvalid", 128'({s0_pv, s1_pv}), 128'h0);
    tick();
    m_pv = 1'b0;

    // slice stall: vaddr stable, both requesters refused
    m_rr = 1'b0;
    s0_rv = 1'b1;
    s0_va = 64'h4000;
    exp_req.push_back(64'h4000);
    tick();
    s1_rv = 1'b1;
    s1_va = 64'h5000;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vaddr", 128'(m_va), 128'h4000);
      chk("stall_ready", 128'({s0_rr, s1_rr}), 128'h0);
      chk("stall_outst", 128'(outst), 128'h1);
      tick();
    end
    s0_rv = 1'b0;
    s1_rv = 1'b0;
    m_rr = 1'b1;
    tick();

    // two more in flight then an asynchronous reset mid-stream
    s0_rv = 1'b1;
    s0_va = 64'h6000;
    exp_req.push_back(64'h6000);
    tick();
    s0_va = 64'h7000;
    tick();
    s0_rv = 1'b0;
    m_rr = 1'b0;
    chk("pre_rst_outst", 128'(outst), 128'h3);
    chk("pre_rst_m_valid", 128'(m_rv), 128'h1);
    chk("req_queue_drained", 128'(exp_req.size()), 128'h0);
    chk("resp_queue_drained", 128'(exp_resp.size()), 128'h0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_outst", 128'(outst), 128'h0);
    chk("async_m_valid", 128'(m_rv), 128'h0);
    exp_req.delete();
    exp_resp.delete();
    tick();
    aresetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
